// File: rtl/rv_dmem_mmio.sv
// rv_dmem_mmio: responder for the CPU data-memory port.
//   addr[31]=0 : byte-enabled data RAM, 2**RAM_AW words (upper address bits alias)
//   addr[31]=1 : MMIO page, offset addr[3:2]
//                0 TXDATA (wr: push byte into TX FIFO, rd: 0)
//                1 STATUS {overflow, fifo_empty&&tx_idle, fifo_full}, wr d[2]=1 clears overflow
//                2 CYCLE_LO (rd also snapshots the high word), 3 CYCLE_HI (snapshot)
// Every access completes in one cycle; dmem_q is registered and changes only on reads.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   dmem_en/addr/d/we request (we==0 means read)
//   dmem_q            registered read data
//   uart_txd          8N1 serial output, idle high
module rv_dmem_mmio #(
  parameter int RAM_AW       = 10,
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_AW      = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dmem_en,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_d,
  input  logic [3:0]  dmem_we,
  output logic [31:0] dmem_q,
  output logic        uart_txd
);
  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_e;

  logic [31:0] mem [2**RAM_AW];
  logic [7:0]  fifo_mem [2**FIFO_AW];

  logic [31:0]      rdata_q, rdata_d;
  logic [63:0]      cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d;
  logic             ovf_q, ovf_d;
  logic [FIFO_AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  tx_state_e        state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [2:0]       bitcnt_q, bitcnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             txd_q, txd_d;

  logic              is_mmio, rd, wr, push_req, push, pop, drop, clr, full, empty, last;
  logic [1:0]        off;
  logic [RAM_AW-1:0] widx;
  logic [31:0]       rsel;
  logic              unused_addr;

  assign is_mmio = dmem_addr[31];
  assign off     = dmem_addr[3:2];
  assign widx    = dmem_addr[RAM_AW+1:2];
  assign rd      = dmem_en && (dmem_we == 4'b0);
  assign wr      = dmem_en && (dmem_we != 4'b0);
  assign unused_addr = ^{dmem_addr[30:RAM_AW+2], dmem_addr[1:0]};

  assign full  = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                 (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);
  assign empty = (wptr_q == rptr_q);
  assign last  = (timer_q == TW'(CLKS_PER_BIT - 1));

  assign push_req = wr && is_mmio && (off == 2'd0) && dmem_we[0];
  // A full FIFO still accepts a byte when the transmitter pops on the same edge.
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;
  assign clr      = wr && is_mmio && (off == 2'd1) && dmem_we[0] && dmem_d[2];

  // Read mux and bookkeeping registers
  always_comb begin
    rsel = 32'b0;
    if (!is_mmio) rsel = mem[widx];
    else begin
      case (off)
        2'd0:    rsel = 32'b0;
        2'd1:    rsel = {29'b0, ovf_q, empty && (state_q == S_IDLE), full};
        2'd2:    rsel = cnt_q[31:0];
        default: rsel = hi_q;
      endcase
    end
    rdata_d = rd ? rsel : rdata_q;
    // LO read captures the matching high word so a following HI read is coherent.
    hi_d    = (rd && is_mmio && (off == 2'd2)) ? cnt_q[63:32] : hi_q;
    cnt_d   = cnt_q + 64'd1;
    // A same-edge drop wins over a software clear.
    ovf_d   = drop ? 1'b1 : (clr ? 1'b0 : ovf_q);
    wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = pop  ? rptr_q + 1'b1 : rptr_q;
  end

  // TX FSM; txd_d is computed for the state being entered so the pin is registered.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    txd_d    = txd_q;
    pop      = 1'b0;
    case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = fifo_mem[rptr_q[FIFO_AW-1:0]];
          state_d = S_START;
          timer_d = '0;
          txd_d   = 1'b0;
        end
      end
      S_START: begin
        if (last) begin
          state_d  = S_DATA;
          timer_d  = '0;
          bitcnt_d = 3'd0;
          txd_d    = shift_q[0];
        end else timer_d = timer_q + TW'(1);
      end
      S_DATA: begin
        if (last) begin
          timer_d = '0;
          if (bitcnt_q == 3'd7) begin
            state_d = S_STOP;
            txd_d   = 1'b1;
          end else begin
            shift_d  = {1'b0, shift_q[7:1]};
            bitcnt_d = bitcnt_q + 3'd1;
            txd_d    = shift_q[1];
          end
        end else timer_d = timer_q + TW'(1);
      end
      default: begin
        if (last) begin
          state_d = S_IDLE;
          timer_d = '0;
          txd_d   = 1'b1;
        end else timer_d = timer_q + TW'(1);
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q  <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      ovf_q    <= 1'b0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      state_q  <= S_IDLE;
      timer_q  <= '0;
      bitcnt_q <= '0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
    end else begin
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      ovf_q    <= ovf_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      state_q  <= state_d;
      timer_q  <= timer_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
    end
  end

  // Storage arrays carry no reset; FIFO contents are discarded by the pointer reset.
  always_ff @(posedge clk) begin
    if (wr && !is_mmio) begin
      for (int b = 0; b < 4; b++)
        if (dmem_we[b]) mem[widx][8*b +: 8] <= dmem_d[8*b +: 8];
    end
    if (push) fifo_mem[wptr_q[FIFO_AW-1:0]] <= dmem_d[7:0];
  end

  assign dmem_q   = rdata_q;
  assign uart_txd = txd_q;
endmodule

// File: tb/tb_rv_dmem_mmio.sv
module tb_rv_dmem_mmio;
  localparam int CPB = 4;
  localparam logic [31:0] A_TX = 32'h8000_0000, A_ST = 32'h8000_0004,
                          A_LO = 32'h8000_0008, A_HI = 32'h8000_000C;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dmem_en;
  logic [31:0] dmem_addr, dmem_d, dmem_q;
  logic [3:0]  dmem_we;
  logic        uart_txd;

  int checks = 0;
  int errors = 0;

  rv_dmem_mmio #(.RAM_AW(10), .CLKS_PER_BIT(CPB), .FIFO_AW(2)) dut (
    .clk(clk), .rst_n(rst_n), .dmem_en(dmem_en), .dmem_addr(dmem_addr),
    .dmem_d(dmem_d), .dmem_we(dmem_we), .dmem_q(dmem_q), .uart_txd(uart_txd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One access on the next rising edge; returns 1 time unit after it.
  task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
    dmem_en = 1'b1; dmem_addr = a; dmem_d = d; dmem_we = we;
    @(posedge clk); #1;
    dmem_en = 1'b0; dmem_we = 4'h0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] q);
    bus(a, 32'h0, 4'h0);
    q = dmem_q;
  endtask

  // Serial receiver: waits for a start bit, samples mid-bit.
  task automatic rx_frame(output logic [7:0] b, output logic ok);
    int n;
    ok = 1'b0; b = 8'h0; n = 0;
    while (uart_txd === 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
    if (uart_txd !== 1'b0) return;
    @(posedge clk); #1;
    if (uart_txd !== 1'b0) return;
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(posedge clk);
      #1; b[i] = uart_txd;
    end
    repeat (CPB) @(posedge clk);
    #1; ok = (uart_txd === 1'b1);
  endtask

  logic [31:0] q, q2;
  logic [7:0]  rxb [5];
  logic        rxok [5];
  logic [7:0]  exp_bit;
  int          lows;

  initial begin
    rst_n = 1'b0; dmem_en = 1'b0; dmem_addr = '0; dmem_d = '0; dmem_we = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_q", dmem_q, 0);
    chk("reset_txd", uart_txd, 1);
    @(negedge clk); rst_n = 1'b1;
    rd(A_ST, q);       chk("status_after_reset", q, 32'h2);

    // RAM word write, read, byte-lane write
    bus(32'h40, 32'h1122_3344, 4'hF);
    chk("q_unchanged_by_write", dmem_q, 32'h2);
    rd(32'h40, q);     chk("lw_0x40", q, 32'h1122_3344);
    bus(32'h40, 32'h00AA_0000, 4'b0100);
    chk("q_unchanged_by_sb", dmem_q, 32'h1122_3344);
    rd(32'h40, q);     chk("sb_lane2", q, 32'h11AA_3344);
    bus(32'h44, 32'hA5A5_A5A5, 4'b0011);
    rd(32'h44, q);     chk("sh_low_lanes", q[15:0], 16'hA5A5);

    // Alias wrap and write with en deasserted
    bus(32'h0, 32'hDEAD_BEEF, 4'hF);
    rd(32'h1000, q);   chk("alias_0x1000", q, 32'hDEAD_BEEF);
    dmem_en = 1'b0; dmem_addr = 32'h0; dmem_d = 32'h0; dmem_we = 4'hF;
    @(posedge clk); #1; dmem_we = 4'h0;
    chk("en0_q_hold", dmem_q, 32'hDEAD_BEEF);
    rd(32'h0, q);      chk("en0_ram_hold", q, 32'hDEAD_BEEF);
    rd(A_TX, q);       chk("txdata_read_zero", q, 0);
    rd(32'h8765_4324, q); chk("mmio_alias_status", q, 32'h2);

    // Cycle counter
    rd(A_LO, q); rd(A_LO, q2);
    chk("cycle_lo_step", q2 - q, 1);
    force dut.cnt_q = 64'h0000_0000_FFFF_FFFF;
    rd(A_LO, q);       chk("cycle_lo_max", q, 32'hFFFF_FFFF);
    force dut.cnt_q = 64'h0000_0001_0000_0000;
    rd(A_HI, q);       chk("cycle_hi_snapshot", q, 32'h0);
    release dut.cnt_q;

    // Single frame, cycle-exact waveform
    bus(A_TX, 32'h0000_0055, 4'h1);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k <= 4) exp_bit = 8'd0;
      else if (k <= 36) exp_bit = {7'd0, 8'h55 >> ((k - 5) / 4)} & 8'd1;
      else exp_bit = 8'd1;
      chk($sformatf("txd_k%0d", k), uart_txd, exp_bit[0]);
      if (k == 20) begin
        rd(A_ST, q); chk("status_busy", q, 32'h0);
        k++;
      end
    end
    rd(A_ST, q);       chk("status_last_stop", q, 32'h0);
    rd(A_ST, q);       chk("status_idle", q, 32'h2);
    bus(A_TX, 32'h0000_0077, 4'h2);
    rd(A_ST, q);       chk("txdata_we0_ignored", q, 32'h2);

    // FIFO fill, overflow, clear, ordering
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          dmem_en = 1'b1; dmem_addr = A_TX; dmem_d = 32'h31 + i; dmem_we = 4'h1;
          @(posedge clk); #1;
        end
        dmem_en = 1'b0; dmem_we = 4'h0;
        rd(A_ST, q);   chk("status_full_ovf", q, 32'h5);
        bus(A_ST, 32'h4, 4'h1);
        rd(A_ST, q);   chk("status_ovf_cleared", q, 32'h1);
      end
      begin
        for (int f = 0; f < 5; f++) rx_frame(rxb[f], rxok[f]);
      end
    join
    for (int f = 0; f < 5; f++) begin
      chk($sformatf("frame%0d_ok", f), rxok[f], 1);
      chk($sformatf("frame%0d_byte", f), rxb[f], 8'h31 + f);
    end
    lows = 0;
    for (int k = 0; k < 80; k++) begin @(posedge clk); #1; if (uart_txd !== 1'b1) lows++; end
    chk("no_sixth_frame", lows, 0);
    rd(A_ST, q);       chk("status_drained", q, 32'h2);

    // Reset in the middle of a data bit
    rd(32'h40, q);
    bus(A_TX, 32'h0000_0000, 4'h1);
    repeat (10) @(posedge clk);
    #1;
    chk("txd_low_mid_data", uart_txd, 0);
    #2; rst_n = 1'b0; #1;
    chk("async_rst_txd", uart_txd, 1);
    chk("async_rst_q", dmem_q, 0);
    @(negedge clk); rst_n = 1'b1;
    rd(A_ST, q);       chk("status_post_reset", q, 32'h2);
    lows = 0;
    for (int k = 0; k < 60; k++) begin @(posedge clk); #1; if (uart_txd !== 1'b1) lows++; end
    chk("no_residual_frame", lows, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
